// File: rtl/rps_match_controller.sv
// Round/match sequencer for rock-paper-scissors: gates the computer's choice
// counter, scores each round from the winner code, and declares a first-to-N winner.
module rps_match_controller #(
  parameter int WINS_TO_MATCH = 2,
  parameter int MAX_ROUNDS    = 7,
  parameter int SHOW_CYCLES   = 4,
  parameter int SCORE_W       = 3,
  parameter int ROUND_W       = 4
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               start,
  input  logic               play,
  input  logic [1:0]         winner,
  output logic               run,
  output logic [SCORE_W-1:0] player_score,
  output logic [SCORE_W-1:0] computer_score,
  output logic [ROUND_W-1:0] round_num,
  output logic [1:0]         last_result,
  output logic               result_valid,
  output logic               match_over,
  output logic [1:0]         match_winner
);

  localparam int CNT_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [SCORE_W-1:0] WINS_L    = SCORE_W'(WINS_TO_MATCH);
  localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);
  localparam logic [ROUND_W-1:0] MAX_L     = ROUND_W'(MAX_ROUNDS);
  localparam logic [ROUND_W-1:0] ROUND_ONE = ROUND_W'(1);
  localparam logic [CNT_W-1:0]   CNT_INIT  = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SPIN = 3'd1,
    EVAL = 3'd2,
    SHOW = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [SCORE_W-1:0] ps_q, ps_d, cs_q, cs_d;
  logic [ROUND_W-1:0] rn_q, rn_d;
  logic [1:0]         last_q, last_d, mw_q, mw_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               end_match;

  // Scores are already final by SHOW, so the end test can look at the flops directly.
  assign end_match = (ps_q == WINS_L) || (cs_q == WINS_L) || (rn_q == MAX_L);

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= IDLE;
      ps_q    <= '0;
      cs_q    <= '0;
      rn_q    <= '0;
      last_q  <= 2'b11;
      mw_q    <= 2'b11;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ps_q    <= ps_d;
      cs_q    <= cs_d;
      rn_q    <= rn_d;
      last_q  <= last_d;
      mw_q    <= mw_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = SPIN; else state_d = state_q;
      SPIN:       if (play)  state_d = EVAL; else state_d = SPIN;
      EVAL:       state_d = SHOW;
      SHOW: begin
        if (cnt_q == '0) state_d = end_match ? DONE : SPIN;
        else             state_d = SHOW;
      end
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    ps_d   = ps_q;
    cs_d   = cs_q;
    rn_d   = rn_q;
    last_d = last_q;
    mw_d   = mw_q;
    cnt_d  = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          ps_d   = '0;
          cs_d   = '0;
          rn_d   = '0;
          last_d = 2'b11;
          mw_d   = 2'b11;
        end
      end
      EVAL: begin
        // Illegal code 10 is folded into a draw and never scores.
        case (winner)
          2'b00: begin
            last_d = 2'b00;
            if (ps_q < WINS_L) ps_d = ps_q + SCORE_ONE;
          end
          2'b01: begin
            last_d = 2'b01;
            if (cs_q < WINS_L) cs_d = cs_q + SCORE_ONE;
          end
          default: last_d = 2'b11;
        endcase
        if (rn_q < MAX_L) rn_d = rn_q + ROUND_ONE;
        cnt_d = CNT_INIT;
      end
      SHOW: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (end_match) begin
          if (ps_q > cs_q)      mw_d = 2'b00;
          else if (cs_q > ps_q) mw_d = 2'b01;
          else                  mw_d = 2'b11;
        end
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  always_comb begin
    run          = (state_q == SPIN);
    result_valid = (state_q == SHOW);
    match_over   = (state_q == DONE);
  end

  assign player_score   = ps_q;
  assign computer_score = cs_q;
  assign round_num      = rn_q;
  assign last_result    = last_q;
  assign match_winner   = mw_q;

endmodule

// File: tb/tb_rps_match_controller.sv
// Directed testbench for rps_match_controller with default parameters
// (first to 2 wins, 7 rounds max, 4-cycle result display).
module tb_rps_match_controller;

  logic       clk = 1'b0;
  logic       clear, start, play;
  logic [1:0] winner;
  logic       run, result_valid, match_over;
  logic [2:0] player_score, computer_score;
  logic [3:0] round_num;
  logic [1:0] last_result, match_winner;

  int errors = 0;
  int checks = 0;

  rps_match_controller dut (
    .clk(clk), .clear(clear), .start(start), .play(play), .winner(winner),
    .run(run), .player_score(player_score), .computer_score(computer_score),
    .round_num(round_num), .last_result(last_result),
    .result_valid(result_valid), .match_over(match_over),
    .match_winner(match_winner)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // One full round from SPIN: play edge, EVAL, then SHOW_CYCLES of SHOW.
  task automatic play_round(input logic [1:0] w);
    winner = w;
    play = 1'b1;
    tick();
    play = 1'b0;
    repeat (5) tick();
  endtask

  task automatic test_reset();
    clear = 1'b1; start = 1'b0; play = 1'b0; winner = 2'b11;
    repeat (2) tick();
    clear = 1'b0;
    tick();
    checks++; if (run !== 1'b0) begin errors++; $display("FAIL reset_run: got %0d expected 0", run); end
    checks++; if (player_score !== 3'd0 || computer_score !== 3'd0) begin errors++; $display("FAIL reset_scores: got %0d/%0d expected 0/0", player_score, computer_score); end
    checks++; if (round_num !== 4'd0) begin errors++; $display("FAIL reset_round: got %0d expected 0", round_num); end
    checks++; if (last_result !== 2'b11 || match_winner !== 2'b11) begin errors++; $display("FAIL reset_codes: got %b/%b expected 11/11", last_result, match_winner); end
    checks++; if (result_valid !== 1'b0 || match_over !== 1'b0) begin errors++; $display("FAIL reset_flags: got %b/%b expected 0/0", result_valid, match_over); end
  endtask

  task automatic test_player_wins();
    pulse_start();
    checks++; if (run !== 1'b1) begin errors++; $display("FAIL p_win_spin: run got %0d expected 1", run); end
    play_round(2'b00);
    checks++; if (player_score !== 3'd1 || run !== 1'b1) begin errors++; $display("FAIL p_win_r1: score got %0d run %0d expected 1 run 1", player_score, run); end
    play_round(2'b00);
    checks++; if (player_score !== 3'd2) begin errors++; $display("FAIL p_win_score: got %0d expected 2", player_score); end
    checks++; if (match_over !== 1'b1 || match_winner !== 2'b00) begin errors++; $display("FAIL p_win_done: got over %0d winner %b expected 1 00", match_over, match_winner); end
    checks++; if (round_num !== 4'd2 || run !== 1'b0) begin errors++; $display("FAIL p_win_round: got %0d run %0d expected 2 run 0", round_num, run); end
  endtask

  task automatic test_computer_wins();
    pulse_start();
    checks++; if (player_score !== 3'd0 || match_winner !== 2'b11 || match_over !== 1'b0) begin errors++; $display("FAIL c_win_restart: got score %0d winner %b over %0d expected 0 11 0", player_score, match_winner, match_over); end
    play_round(2'b01);
    play_round(2'b00);
    checks++; if (match_over !== 1'b0 || last_result !== 2'b00) begin errors++; $display("FAIL c_win_mid: got over %0d last %b expected 0 00", match_over, last_result); end
    play_round(2'b01);
    checks++; if (player_score !== 3'd1 || computer_score !== 3'd2) begin errors++; $display("FAIL c_win_scores: got %0d/%0d expected 1/2", player_score, computer_score); end
    checks++; if (match_over !== 1'b1 || match_winner !== 2'b01 || round_num !== 4'd3) begin errors++; $display("FAIL c_win_done: got over %0d winner %b round %0d expected 1 01 3", match_over, match_winner, round_num); end
  endtask

  task automatic test_draw_limit();
    pulse_start();
    for (int i = 0; i < 7; i++) begin
      play_round((i == 3) ? 2'b10 : 2'b11);
      checks++; if (last_result !== 2'b11) begin errors++; $display("FAIL draw_last_%0d: got %b expected 11", i, last_result); end
      if (i == 5) begin
        checks++; if (match_over !== 1'b0) begin errors++; $display("FAIL draw_early_done: got %0d expected 0", match_over); end
      end
    end
    checks++; if (player_score !== 3'd0 || computer_score !== 3'd0) begin errors++; $display("FAIL draw_scores: got %0d/%0d expected 0/0", player_score, computer_score); end
    checks++; if (round_num !== 4'd7 || match_over !== 1'b1 || match_winner !== 2'b11) begin errors++; $display("FAIL draw_done: got round %0d over %0d winner %b expected 7 1 11", round_num, match_over, match_winner); end
  endtask

  task automatic test_timing();
    int hi;
    pulse_start();
    winner = 2'b00;
    play = 1'b1;
    tick();
    play = 1'b0;
    checks++; if (run !== 1'b0 || result_valid !== 1'b0 || player_score !== 3'd0) begin errors++; $display("FAIL timing_eval: got run %0d rv %0d score %0d expected 0 0 0", run, result_valid, player_score); end
    tick();
    checks++; if (result_valid !== 1'b1 || player_score !== 3'd1 || round_num !== 4'd1) begin errors++; $display("FAIL timing_show: got rv %0d score %0d round %0d expected 1 1 1", result_valid, player_score, round_num); end
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      if (result_valid === 1'b1) hi++;
      tick();
    end
    checks++; if (hi !== 4) begin errors++; $display("FAIL timing_show_len: got %0d expected 4", hi); end
    checks++; if (run !== 1'b1) begin errors++; $display("FAIL timing_rerun: got %0d expected 1", run); end
  endtask

  // Continues the match left by test_timing (P1 C0, one round played).
  task automatic test_ignored_inputs();
    winner = 2'b01;
    play = 1'b1;
    tick();
    play = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    play = 1'b1;
    tick();
    play = 1'b0;
    checks++; if (result_valid !== 1'b1 || computer_score !== 3'd1) begin errors++; $display("FAIL ign_show: got rv %0d cscore %0d expected 1 1", result_valid, computer_score); end
    repeat (2) tick();
    checks++; if (run !== 1'b1 || player_score !== 3'd1 || computer_score !== 3'd1 || round_num !== 4'd2) begin errors++; $display("FAIL ign_after_show: got run %0d %0d/%0d round %0d expected 1 1/1 2", run, player_score, computer_score, round_num); end
    winner = 2'b00;
    start = 1'b1;
    play = 1'b1;
    tick();
    start = 1'b0;
    play = 1'b0;
    checks++; if (run !== 1'b0 || player_score !== 3'd1 || round_num !== 4'd2) begin errors++; $display("FAIL ign_start_play: got run %0d score %0d round %0d expected 0 1 2", run, player_score, round_num); end
    repeat (5) tick();
    checks++; if (match_over !== 1'b1 || match_winner !== 2'b00 || player_score !== 3'd2) begin errors++; $display("FAIL ign_done: got over %0d winner %b score %0d expected 1 00 2", match_over, match_winner, player_score); end
    play = 1'b1;
    repeat (2) tick();
    play = 1'b0;
    checks++; if (match_over !== 1'b1 || run !== 1'b0 || round_num !== 4'd3) begin errors++; $display("FAIL ign_play_done: got over %0d run %0d round %0d expected 1 0 3", match_over, run, round_num); end
  endtask

  task automatic test_clear_restart();
    pulse_start();
    winner = 2'b00;
    play = 1'b1;
    tick();
    play = 1'b0;
    tick();
    checks++; if (player_score !== 3'd1 || result_valid !== 1'b1) begin errors++; $display("FAIL clr_pre: got score %0d rv %0d expected 1 1", player_score, result_valid); end
    #2 clear = 1'b1;
    #1;
    checks++; if (player_score !== 3'd0 || round_num !== 4'd0 || result_valid !== 1'b0 || run !== 1'b0) begin errors++; $display("FAIL clr_async: got score %0d round %0d rv %0d run %0d expected 0 0 0 0", player_score, round_num, result_valid, run); end
    checks++; if (last_result !== 2'b11 || match_winner !== 2'b11 || match_over !== 1'b0) begin errors++; $display("FAIL clr_codes: got %b/%b over %0d expected 11/11 0", last_result, match_winner, match_over); end
    clear = 1'b0;
    play = 1'b1;
    tick();
    play = 1'b0;
    checks++; if (run !== 1'b0 || result_valid !== 1'b0 || round_num !== 4'd0) begin errors++; $display("FAIL clr_idle_play: got run %0d rv %0d round %0d expected 0 0 0", run, result_valid, round_num); end
    pulse_start();
    checks++; if (run !== 1'b1) begin errors++; $display("FAIL clr_start: got %0d expected 1", run); end
    play_round(2'b01);
    play_round(2'b01);
    checks++; if (match_over !== 1'b1 || match_winner !== 2'b01) begin errors++; $display("FAIL clr_done: got over %0d winner %b expected 1 01", match_over, match_winner); end
    pulse_start();
    checks++; if (run !== 1'b1 || computer_score !== 3'd0 || match_winner !== 2'b11 || round_num !== 4'd0) begin errors++; $display("FAIL clr_restart: got run %0d cscore %0d winner %b round %0d expected 1 0 11 0", run, computer_score, match_winner, round_num); end
  endtask

  initial begin
    test_reset();
    test_player_wins();
    test_computer_wins();
    test_draw_limit();
    test_timing();
    test_ignored_inputs();
    test_clear_restart();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rps_match_controller.md
Name: rps_match_controller

Overview:
- Round/match sequencer that sits directly downstream of the winner indicator and upstream of the display.
- Gates the computer's R/P/S counter through its run output and samples the 2-bit winner code once per round.
- Keeps player/computer scores and a round count, and declares a first-to-N match winner.

Parameters:
- WINS_TO_MATCH, 2, round wins needed to take the match (range 1..2^SCORE_W-1).
- MAX_ROUNDS, 7, round limit; when reached, the match ends on current scores.
- SHOW_CYCLES, 4, cycles the round result is held in SHOW (minimum 1).
- SCORE_W, 3, width of the score counters.
- ROUND_W, 4, width of the round counter (must hold MAX_ROUNDS).

Ports:
- clk  in  1  system clock, rising-edge.
- clear  in  1  asynchronous active-high reset.
- start  in  1  single-cycle pulse: begin a new match; honoured only in IDLE or DONE.
- play  in  1  single-cycle pulse: player commits the current choice; honoured only in SPIN.
- winner  in  2  from winner indicator: 00 player, 01 computer, 11 draw, 10 illegal.
- run  out  1  1 = computer counter cycles; 0 = frozen.
- player_score  out  SCORE_W  player round wins.
- computer_score  out  SCORE_W  computer round wins.
- round_num  out  ROUND_W  rounds completed in the current match.
- last_result  out  2  winner code of the most recent round (10 mapped to 11).
- result_valid  out  1  high while in SHOW.
- match_over  out  1  high while in DONE.
- match_winner  out  2  00 player, 01 computer, 11 draw/none.

Behaviour:
- Reset (clear=1, asynchronous): state=IDLE, run=0, all scores=0, round_num=0, last_result=11, result_valid=0, match_over=0, match_winner=11, show counter=0.
- All outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.
- States: IDLE, SPIN, EVAL, SHOW, DONE.
- IDLE:
  - start -> SPIN.
  - On that edge, clear scores and round_num; set last_result=11 and match_winner=11.
- SPIN:
  - run=1.
  - play -> EVAL; run is 0 from the next cycle, so the counter freezes on the play edge.
  - start is ignored.
- EVAL: exactly one cycle, run=0; winner is sampled at the end of this cycle.
  - 00: player_score+1.
  - 01: computer_score+1.
  - 11 or 10: no score change, and last_result=11.
  - round_num+1 in every case.
  - Next state is SHOW with show counter loaded to SHOW_CYCLES-1.
- SHOW:
  - result_valid=1, run=0.
  - Counter decrements each cycle; at 0, transition on the next edge.
  - If player_score==WINS_TO_MATCH, computer_score==WINS_TO_MATCH, or round_num==MAX_ROUNDS, go to DONE; otherwise go to SPIN.
- DONE entry sets match_winner:
  - player_score>computer_score gives 00.
  - computer_score>player_score gives 01.
  - Equal scores give 11.
- DONE:
  - match_over=1, run=0; scores and match_winner hold.
  - start -> SPIN with the same clearing as from IDLE.
- Latency: play pulse to scores updated is 2 edges (SPIN->EVAL, EVAL->SHOW). Round turnaround is SHOW_CYCLES+2 cycles minimum.
- Scores never exceed WINS_TO_MATCH and never wrap. round_num never exceeds MAX_ROUNDS.
- Ignored-input cases:
  - play outside SPIN is ignored, including a play held high across states; only a play sampled in SPIN counts.
  - start in SPIN/EVAL/SHOW is ignored.
  - start and play in the same SPIN cycle: play is taken, start is dropped.
- clear asserted mid-round (any state): immediate return to reset values with run=0. The first rising clk edge after release with start=1 enters SPIN.
- An illegal winner code 10 is treated as a draw and never scores.

Test Plan:
1. Reset, start, play with winner=00 at EVAL, twice (WINS_TO_MATCH=2) -> player_score 1 then 2; DONE; match_over=1; match_winner=00; round_num=2.
2. Alternate winner 01, 00, 01 across rounds -> scores end P1/C2; match_winner=01; DONE reached after the third SHOW.
3. Seven consecutive draws (winner=11), one with winner=10 -> scores 0/0; round_num=7; DONE; match_winner=11; last_result=11 throughout.
4. Timing check: play at cycle t in SPIN -> run=0 at t+1; result_valid high for exactly SHOW_CYCLES cycles starting t+2; run=1 again after SHOW if the match is not over.
5. Pulse start during SHOW and play during SHOW/DONE/IDLE -> no state or score change. start+play together in SPIN -> EVAL entered, scores not cleared.
6. Assert clear during SHOW with player_score=1 -> all outputs at reset values immediately, without waiting for a clk edge. Then start, then a DONE->start restart -> scores cleared, match_winner=11, run=1.
